// File: rtl/mem_port_arbiter.sv
// Merges the CPU instruction and data ports onto one backing-memory port.
// One transaction at a time; arbitration is round-robin or data-first.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit FAIR_RR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_mem_address,
    output logic [DATA_W-1:0] instr_mem_rdata,
    output logic              instr_mem_resp,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_mem_address,
    input  logic [DATA_W-1:0] data_mem_wdata,
    input  logic [3:0]        data_mbe,
    output logic [DATA_W-1:0] data_mem_rdata,
    output logic              data_mem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_mbe,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds read/write for at least the IDLE sample;
    // it is then latched and ignored until the one-cycle resp pulse in DONE.
    // The memory side sees read/write held until it returns mem_resp.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   last_grant_d;
    logic   data_req;
    logic   grant_i, grant_d;

    assign data_req  = data_read | data_write;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && instr_read) begin
                    // Only the fair mode ever hands a contended slot to instructions
                    if (FAIR_RR && last_grant_d) grant_i = 1'b1;
                    else                         grant_d = 1'b1;
                end else if (data_req) begin
                    grant_d = 1'b1;
                end else if (instr_read) begin
                    grant_i = 1'b1;
                end
                if (grant_d)      state_nxt = BUSY_D;
                else if (grant_i) state_nxt = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_d    <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_mbe         <= 4'h0;
            instr_mem_rdata <= '0;
            instr_mem_resp  <= 1'b0;
            data_mem_rdata  <= '0;
            data_mem_resp   <= 1'b0;
        end else begin
            instr_mem_resp <= 1'b0;
            data_mem_resp  <= 1'b0;
            if (grant_i) begin
                mem_read    <= 1'b1;
                mem_write   <= 1'b0;
                mem_address <= {instr_mem_address[ADDR_W-1:2], 2'b00};
                mem_wdata   <= '0;
                mem_mbe     <= 4'hF;
            end else if (grant_d) begin
                // A simultaneous read+write is treated as a write
                mem_read    <= ~data_write;
                mem_write   <= data_write;
                mem_address <= {data_mem_address[ADDR_W-1:2], 2'b00};
                mem_wdata   <= data_write ? data_mem_wdata : '0;
                mem_mbe     <= data_write ? data_mbe : 4'hF;
            end
            if (mem_resp && (state == BUSY_I || state == BUSY_D)) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                if (state == BUSY_I) begin
                    instr_mem_rdata <= mem_rdata;
                    instr_mem_resp  <= 1'b1;
                    last_grant_d    <= 1'b0;
                end else begin
                    data_mem_rdata <= mem_rdata;
                    data_mem_resp  <= 1'b1;
                    last_grant_d   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance with a variable
// latency memory model and a fixed-priority instance with a 1-cycle memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_rdata;
    logic        data_mem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic [1:0]  dbg_state;

    logic        fx_instr_read;
    logic        fx_data_read;
    logic [31:0] fx_instr_rdata;
    logic        fx_instr_resp;
    logic [31:0] fx_data_rdata;
    logic        fx_data_resp;
    logic        m2_read;
    logic        m2_write;
    logic [31:0] m2_address;
    logic [31:0] m2_wdata;
    logic [3:0]  m2_mbe;
    logic [31:0] m2_rdata;
    logic        m2_resp;
    logic [1:0]  fx_state;

    int checks = 0;
    int failures = 0;
    int mem_lat = 1;
    int dual_cnt = 0;
    logic [32:0] resp_q[$];
    logic [32:0] grant_q[$];
    logic [32:0] exp_q[$];
    logic        fx_q[$];

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_RR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .instr_read(instr_read), .instr_mem_address(instr_mem_address),
        .instr_mem_rdata(instr_mem_rdata), .instr_mem_resp(instr_mem_resp),
        .data_read(data_read), .data_write(data_write),
        .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
        .data_mbe(data_mbe), .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_mbe(mem_mbe), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_RR(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .instr_read(fx_instr_read), .instr_mem_address(32'h0000_0300),
        .instr_mem_rdata(fx_instr_rdata), .instr_mem_resp(fx_instr_resp),
        .data_read(fx_data_read), .data_write(1'b0),
        .data_mem_address(32'h0000_0400), .data_mem_wdata(32'h0),
        .data_mbe(4'h0), .data_mem_rdata(fx_data_rdata), .data_mem_resp(fx_data_resp),
        .mem_read(m2_read), .mem_write(m2_write), .mem_address(m2_address),
        .mem_wdata(m2_wdata), .mem_mbe(m2_mbe), .mem_rdata(m2_rdata),
        .mem_resp(m2_resp), .dbg_state(fx_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0060) return 32'h0000_0013;
        return {16'hC0DE, a[15:0]};
    endfunction

    // memory model for the round-robin instance
    initial begin
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            tick();
            if ((mem_read || mem_write) && !mem_resp) begin
                grant_q.push_back({mem_write, mem_address});
                repeat (mem_lat - 1) tick();
                mem_rdata = mem_fn(mem_address);
                mem_resp  = 1'b1;
                tick();
                mem_resp  = 1'b0;
            end
        end
    end

    // memory model for the fixed-priority instance
    initial begin
        m2_resp  = 1'b0;
        m2_rdata = 32'h0;
        forever begin
            tick();
            if ((m2_read || m2_write) && !m2_resp) begin
                m2_rdata = {16'hF1F0, m2_address[15:0]};
                m2_resp  = 1'b1;
            end else begin
                m2_resp  = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (instr_mem_resp) resp_q.push_back({1'b0, instr_mem_rdata});
        if (data_mem_resp)  resp_q.push_back({1'b1, data_mem_rdata});
        if (instr_mem_resp && data_mem_resp) dual_cnt++;
        if (fx_data_resp)  fx_q.push_back(1'b1);
        if (fx_instr_resp) fx_q.push_back(1'b0);
    end

    // driver tasks
    task automatic wait_resp(input bit port_d, input logic [31:0] exp, input string tag);
        int n = 0;
        while (!(port_d ? data_mem_resp : instr_mem_resp) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check({tag, "_timeout"}, 64'(n), 64'd0);
        end else begin
            check({tag, "_rdata"}, port_d ? data_mem_rdata : instr_mem_rdata, exp);
            check({tag, "_other_resp"}, port_d ? instr_mem_resp : data_mem_resp, 0);
            tick();
            check({tag, "_pulse_end"}, port_d ? data_mem_resp : instr_mem_resp, 0);
            check({tag, "_mem_drop"}, {mem_read, mem_write}, 0);
            check({tag, "_rdata_hold"}, port_d ? data_mem_rdata : instr_mem_rdata, exp);
        end
    endtask

    initial begin
        int base;
        int gbase;
        int n;
        rst = 1'b0;
        instr_read = 0; instr_mem_address = 0;
        data_read = 0; data_write = 0; data_mem_address = 0;
        data_mem_wdata = 0; data_mbe = 0;
        fx_instr_read = 0; fx_data_read = 0;
        repeat (3) tick();
        check("rst_state", dbg_state, S_IDLE);
        check("rst_mem_rw", {mem_read, mem_write}, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_mbe", mem_mbe, 0);
        check("rst_resp", {instr_mem_resp, data_mem_resp}, 0);
        check("rst_rdata", {instr_mem_rdata, data_mem_rdata}, 0);
        rst = 1'b1;
        tick();

        // single fetch, memory answers after 3 cycles
        mem_lat = 3;
        instr_read = 1; instr_mem_address = 32'h60;
        tick();
        check("fetch_mem_read", {mem_read, mem_write}, 2'b10);
        check("fetch_address", mem_address, 32'h60);
        check("fetch_mbe", mem_mbe, 4'hF);
        check("fetch_state", dbg_state, S_BUSY_I);
        instr_read = 0;
        wait_resp(1'b0, 32'h13, "fetch");

        // store with unaligned address, then load
        mem_lat = 1;
        data_write = 1; data_mem_address = 32'h1003;
        data_mem_wdata = 32'hAB00_0000; data_mbe = 4'b1000;
        tick();
        check("store_rw", {mem_read, mem_write}, 2'b01);
        check("store_address", mem_address, 32'h1000);
        check("store_wdata", mem_wdata, 32'hAB00_0000);
        check("store_mbe", mem_mbe, 4'b1000);
        data_write = 0;
        wait_resp(1'b1, 32'hC0DE_1000, "store");
        data_read = 1; data_mem_address = 32'h1000;
        tick();
        check("load_rw", {mem_read, mem_write}, 2'b10);
        check("load_mbe", mem_mbe, 4'hF);
        data_read = 0;
        wait_resp(1'b1, 32'hC0DE_1000, "load");

        // withdrawal during BUSY_D
        mem_lat = 3;
        data_read = 1; data_mem_address = 32'h1000;
        tick();
        check("wd_state", dbg_state, S_BUSY_D);
        data_read = 0; data_mem_address = 32'h2000;
        tick();
        check("wd_address", mem_address, 32'h1000);
        check("wd_read_held", mem_read, 1);
        wait_resp(1'b1, 32'hC0DE_1000, "withdraw");

        // illegal read+write: write wins
        mem_lat = 1;
        data_read = 1; data_write = 1; data_mem_address = 32'h0500;
        data_mem_wdata = 32'h1234_5678; data_mbe = 4'b0011;
        tick();
        check("rw_both_rw", {mem_read, mem_write}, 2'b01);
        check("rw_both_mbe", mem_mbe, 4'b0011);
        data_read = 0; data_write = 0;
        wait_resp(1'b1, 32'hC0DE_0500, "rw_both");

        // reset mid-transaction
        mem_lat = 5;
        instr_read = 1; instr_mem_address = 32'h40;
        tick();
        check("mrst_pre_read", mem_read, 1);
        instr_read = 0;
        #2 rst = 1'b0;
        #1;
        check("mrst_async_read", mem_read, 0);
        check("mrst_async_state", dbg_state, S_IDLE);
        tick();
        rst = 1'b1;
        base = resp_q.size();
        repeat (8) tick();
        check("mrst_no_resp", 64'(resp_q.size()), 64'(base));
        check("mrst_idle", dbg_state, S_IDLE);
        mem_lat = 2;
        instr_read = 1; instr_mem_address = 32'h80;
        tick();
        check("mrst_next_addr", mem_address, 32'h80);
        instr_read = 0;
        wait_resp(1'b0, 32'hC0DE_0080, "mrst_next");

        // contention after reset: expect D, I, D, I
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_lat = 1;
        base = resp_q.size();
        gbase = grant_q.size();
        instr_read = 1; instr_mem_address = 32'h100;
        data_read = 1; data_mem_address = 32'h200;
        n = 0;
        while (resp_q.size() < base + 4 && n < 200) begin
            tick();
            n++;
        end
        instr_read = 0; data_read = 0;
        repeat (10) tick();
        check("cont_count", 64'(resp_q.size() >= base + 4), 1);
        exp_q.push_back({1'b1, 32'hC0DE_0200});
        exp_q.push_back({1'b0, 32'hC0DE_0100});
        exp_q.push_back({1'b1, 32'hC0DE_0200});
        exp_q.push_back({1'b0, 32'hC0DE_0100});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_resp%0d", i), resp_q[base + i], exp_q[i]);
            check($sformatf("cont_grant%0d", i), grant_q[gbase + i],
                  {1'b0, exp_q[i][32] ? 32'h200 : 32'h100});
        end
        check("no_dual_resp", 64'(dual_cnt), 0);

        // fixed priority instance
        fx_instr_read = 1; fx_data_read = 1;
        n = 0;
        while (fx_q.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        fx_data_read = 0;
        n = 0;
        while (fx_q.size() < 4 && n < 100) begin
            tick();
            n++;
        end
        fx_instr_read = 0;
        repeat (6) tick();
        check("fix_count", 64'(fx_q.size() >= 4), 1);
        for (int i = 0; i < 3; i++)
            check($sformatf("fix_data%0d", i), fx_q[i], 1);
        check("fix_instr_after", fx_q[3], 0);
        check("fix_rdata", fx_instr_rdata, 32'hF1F0_0300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
